// File: rtl/stream_xbar_router.sv
// Multicast ready/valid crossbar with per-output 2-entry skid buffers, isolate/drain FSMs and
// shadowed reconfiguration. Optional output tap is enabled by defining ROUTER_TAP_EN.
module stream_xbar_router #(
    parameter int unsigned WIDTH_BITS = 40,
    parameter int unsigned IN_PORTS   = 4,
    parameter int unsigned OUT_PORTS  = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SEL_W      = $clog2(IN_PORTS),
    parameter int unsigned TSEL_W     = (OUT_PORTS > 1) ? $clog2(OUT_PORTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IN_PORTS-1:0][WIDTH_BITS-1:0]  in_data_i,
    input  logic [IN_PORTS-1:0]                  in_valid_i,
    output logic [IN_PORTS-1:0]                  in_ready_o,
    output logic [OUT_PORTS-1:0][WIDTH_BITS-1:0] out_data_o,
    output logic [OUT_PORTS-1:0]                 out_valid_o,
    input  logic [OUT_PORTS-1:0]                 out_ready_i,
    input  logic [OUT_PORTS-1:0][SEL_W-1:0]      cfg_sel_i,
    input  logic [OUT_PORTS-1:0]                 cfg_en_i,
    input  logic                                 cfg_update_i,
    output logic                                 cfg_busy_o,
    input  logic [OUT_PORTS-1:0]                 isolate_i,
    output logic [OUT_PORTS-1:0]                 isolated_o,
    input  logic [TSEL_W-1:0]                    tap_sel_i,
    output logic [WIDTH_BITS-1:0]                tap_data_o,
    output logic                                 tap_valid_o,
    output logic [CNT_W-1:0]                     tap_beats_o
);
    typedef enum logic [1:0] {StActive, StDrain, StIsolated} out_st_e;
    typedef enum logic [1:0] {StIdle, StFreeze, StApply} cfg_st_e;

    out_st_e                              ost_q [OUT_PORTS];
    out_st_e                              ost_d [OUT_PORTS];
    cfg_st_e                              cst_q, cst_d;
    logic [OUT_PORTS-1:0][SEL_W-1:0]      sel_q, sel_d, shadow_sel_q, shadow_sel_d;
    logic [OUT_PORTS-1:0]                 en_q, en_d, shadow_en_q, shadow_en_d;
    logic [OUT_PORTS-1:0][WIDTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [OUT_PORTS-1:0][1:0]            cnt_q, cnt_d;
    logic [OUT_PORTS-1:0]                 live, push, pop;
    logic [IN_PORTS-1:0]                  subscribed, blocked;
    logic                                 freeze, all_empty;

    // Ready depends only on registered state, never on out_ready_i.
    always_comb begin
        freeze     = (cst_q != StIdle);
        subscribed = '0;
        blocked    = '0;
        for (int k = 0; k < OUT_PORTS; k++) begin
            live[k] = en_q[k] & (ost_q[k] == StActive);
            if (live[k]) begin
                subscribed[sel_q[k]] = 1'b1;
                if (cnt_q[k] == 2'd2) blocked[sel_q[k]] = 1'b1;
            end
        end
        in_ready_o = ~{IN_PORTS{freeze}} & subscribed & ~blocked;
        for (int k = 0; k < OUT_PORTS; k++) begin
            push[k] = live[k] & in_valid_i[sel_q[k]] & in_ready_o[sel_q[k]];
            pop[k]  = (cnt_q[k] != 2'd0) & out_ready_i[k];
        end
    end

    // Push with pop only happens at count 1, since a full buffer holds its input's ready low.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < OUT_PORTS; k++) begin
            case ({push[k], pop[k]})
                2'b10: begin
                    if (cnt_q[k] == 2'd0) head_d[k] = in_data_i[sel_q[k]];
                    else                  tail_d[k] = in_data_i[sel_q[k]];
                    cnt_d[k] = cnt_q[k] + 2'd1;
                end
                2'b01: begin
                    head_d[k] = tail_q[k];
                    cnt_d[k]  = cnt_q[k] - 2'd1;
                end
                2'b11:   head_d[k] = in_data_i[sel_q[k]];
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_PORTS; k++) begin
            ost_d[k] = ost_q[k];
            case (ost_q[k])
                StActive:   if (isolate_i[k]) ost_d[k] = StDrain;
                StDrain: begin
                    if (!isolate_i[k])          ost_d[k] = StActive;
                    else if (cnt_q[k] == 2'd0)  ost_d[k] = StIsolated;
                end
                StIsolated: if (!isolate_i[k]) ost_d[k] = StActive;
                default:    ost_d[k] = StActive;
            endcase
        end
    end

    always_comb begin
        cst_d        = cst_q;
        sel_d        = sel_q;
        en_d         = en_q;
        shadow_sel_d = shadow_sel_q;
        shadow_en_d  = shadow_en_q;
        all_empty    = 1'b1;
        for (int k = 0; k < OUT_PORTS; k++) begin
            if ((cnt_q[k] != 2'd0) && (ost_q[k] != StIsolated)) all_empty = 1'b0;
        end
        case (cst_q)
            StIdle: begin
                if (cfg_update_i) begin
                    shadow_sel_d = cfg_sel_i;
                    shadow_en_d  = cfg_en_i;
                    cst_d        = StFreeze;
                end
            end
            StFreeze: if (all_empty) cst_d = StApply;
            StApply: begin
                sel_d = shadow_sel_q;
                en_d  = shadow_en_q;
                cst_d = StIdle;
            end
            default: cst_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst_q        <= StIdle;
            sel_q        <= '0;
            en_q         <= '0;
            shadow_sel_q <= '0;
            shadow_en_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            for (int k = 0; k < OUT_PORTS; k++) ost_q[k] <= StActive;
        end else begin
            cst_q        <= cst_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            shadow_sel_q <= shadow_sel_d;
            shadow_en_q  <= shadow_en_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            for (int k = 0; k < OUT_PORTS; k++) ost_q[k] <= ost_d[k];
        end
    end

    always_comb begin
        cfg_busy_o = freeze;
        out_data_o = head_q;
        for (int k = 0; k < OUT_PORTS; k++) begin
            out_valid_o[k] = (cnt_q[k] != 2'd0);
            isolated_o[k]  = (ost_q[k] == StIsolated);
        end
    end

`ifdef ROUTER_TAP_EN
    logic [TSEL_W-1:0] tap_sel_q;
    logic [CNT_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic              tap_ok, tap_hs;

    always_comb begin
        tap_ok    = (int'(tap_sel_i) < int'(OUT_PORTS));
        tap_hs    = tap_ok & out_valid_o[tap_sel_i] & out_ready_i[tap_sel_i];
        tap_cnt_d = tap_cnt_q;
        if (tap_sel_i != tap_sel_q)           tap_cnt_d = '0;
        else if (tap_hs && (tap_cnt_q != '1)) tap_cnt_d = tap_cnt_q + 1'b1;
        tap_valid_o = tap_ok & out_valid_o[tap_sel_i];
        tap_data_o  = tap_ok ? out_data_o[tap_sel_i] : '0;
        tap_beats_o = tap_ok ? tap_cnt_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_sel_q <= '0;
            tap_cnt_q <= '0;
        end else begin
            tap_sel_q <= tap_sel_i;
            tap_cnt_q <= tap_cnt_d;
        end
    end
`else
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel_i;
    assign tap_data_o     = '0;
    assign tap_valid_o    = 1'b0;
    assign tap_beats_o    = '0;
`endif
endmodule

// File: tb/tb_stream_xbar_router.sv
// Directed bench for stream_xbar_router: vector table for the 2-route datapath, hand-written
// multicast/isolate/reconfig sequences, and a scoreboarded random run with mid-run reset.
module tb_stream_xbar_router;
    localparam int W  = 40;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int CW = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NI-1:0][W-1:0]  in_data;
    logic [NI-1:0]         in_valid, in_ready;
    logic [NO-1:0][W-1:0]  out_data;
    logic [NO-1:0]         out_valid, out_ready;
    logic [NO-1:0][1:0]    cfg_sel;
    logic [NO-1:0]         cfg_en;
    logic                  cfg_update, cfg_busy;
    logic [NO-1:0]         isolate, isolated;
    logic                  tap_sel;
    logic [W-1:0]          tap_data;
    logic                  tap_valid;
    logic [CW-1:0]         tap_beats;

    stream_xbar_router dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .cfg_sel_i    (cfg_sel),
        .cfg_en_i     (cfg_en),
        .cfg_update_i (cfg_update),
        .cfg_busy_o   (cfg_busy),
        .isolate_i    (isolate),
        .isolated_o   (isolated),
        .tap_sel_i    (tap_sel),
        .tap_data_o   (tap_data),
        .tap_valid_o  (tap_valid),
        .tap_beats_o  (tap_beats)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: bench-side copy of the applied routing, one expected-beat queue per output.
    logic          sb_on = 1'b0;
    logic [1:0]    tb_sel [NO];
    logic [NO-1:0] tb_en = '0;
    logic [W-1:0]  q0 [$];
    logic [W-1:0]  q1 [$];

    always @(negedge clk) begin
        if (sb_on) begin
            if (out_valid[0] && out_ready[0]) begin
                if (q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_out0: got beat %0h, expected none", out_data[0]);
                end else chk("sb_out0_order", out_data[0], q0.pop_front());
            end
            if (out_valid[1] && out_ready[1]) begin
                if (q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_out1: got beat %0h, expected none", out_data[1]);
                end else chk("sb_out1_order", out_data[1], q1.pop_front());
            end
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    if (tb_en[0] && int'(tb_sel[0]) == i) q0.push_back(in_data[i]);
                    if (tb_en[1] && int'(tb_sel[1]) == i) q1.push_back(in_data[i]);
                end
            end
        end
    end

    task automatic reconfig(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] en,
                            output int ncyc);
        cfg_sel[0] = s0;
        cfg_sel[1] = s1;
        cfg_en     = en;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        chk("cfg_busy_after_update", cfg_busy, 1);
        ncyc = 0;
        while (cfg_busy && ncyc < 50) begin
            step();
            ncyc++;
        end
        chk("cfg_reconfig_done", cfg_busy, 0);
        tb_sel[0] = s0;
        tb_sel[1] = s1;
        tb_en     = en;
    endtask

    typedef struct {
        logic [3:0]   vld;
        logic [W-1:0] d1, d3;
        logic [1:0]   ordy;
        logic [3:0]   rdy;
        logic [1:0]   ov;
        logic [W-1:0] q0, q1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // out0 <- in1, out1 <- in3; in0/in2 unrouted
        tbl[0] = '{4'b0010, 40'hA5, 40'h0,  2'b00, 4'b1010, 2'b01, 40'hA5, 40'h0};
        tbl[1] = '{4'b1010, 40'hB1, 40'hC1, 2'b00, 4'b1010, 2'b11, 40'hA5, 40'hC1};
        tbl[2] = '{4'b1010, 40'hB2, 40'hC2, 2'b00, 4'b1000, 2'b11, 40'hA5, 40'hC1};
        tbl[3] = '{4'b1010, 40'hB2, 40'hC3, 2'b11, 4'b0000, 2'b11, 40'hB1, 40'hC2};
        tbl[4] = '{4'b1010, 40'hB2, 40'hC3, 2'b11, 4'b1010, 2'b11, 40'hB2, 40'hC3};
        tbl[5] = '{4'b0000, 40'h0,  40'h0,  2'b01, 4'b1010, 2'b10, 40'h0,  40'hC3};
        tbl[6] = '{4'b0101, 40'h0,  40'h0,  2'b11, 4'b1010, 2'b00, 40'h0,  40'h0};

        in_data = '0; in_valid = '0; out_ready = '0; cfg_sel = '0; cfg_en = '0;
        cfg_update = 1'b0; isolate = '0; tap_sel = 1'b0;
        tb_sel[0] = 2'd0; tb_sel[1] = 2'd0;

        #12;
        in_valid = 4'b1111;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", cfg_busy, 0);
        chk("reset_isolated", isolated, 0);
        chk("reset_out_data", out_data, 0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_in_ready", in_ready, 0);

        reconfig(2'd1, 2'd3, 2'b11, n);
        chk("cfg_busy_cycles", n, 2);

        for (int r = 0; r < 7; r++) begin
            in_valid   = tbl[r].vld;
            in_data[0] = 40'hDEAD0;
            in_data[1] = tbl[r].d1;
            in_data[2] = 40'hDEAD2;
            in_data[3] = tbl[r].d3;
            out_ready  = tbl[r].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", r), in_ready, tbl[r].rdy);
            step();
            chk($sformatf("vec%0d_out_valid", r), out_valid, tbl[r].ov);
            if (tbl[r].ov[0]) chk($sformatf("vec%0d_out0_data", r), out_data[0], tbl[r].q0);
            if (tbl[r].ov[1]) chk($sformatf("vec%0d_out1_data", r), out_data[1], tbl[r].q1);
        end
        in_valid = '0;
`ifdef ROUTER_TAP_EN
        chk("tap_default_sel0_valid", tap_valid, out_valid[0]);
`else
        chk("tap_tied_off", {tap_valid, tap_beats, tap_data}, 0);
`endif

        // Multicast: both outputs on in2, out1 stalled.
        reconfig(2'd2, 2'd2, 2'b11, n);
        sb_on = 1'b1;
        in_valid = 4'b0100;
        out_ready = 2'b01;
        for (int c = 0; c < 3; c++) begin
            in_data[2] = 40'hD0 + 40'(c);
            #1;
            chk($sformatf("mc_ready_c%0d", c), in_ready[2], (c < 2) ? 1 : 0);
            step();
        end
        in_valid = '0;
        out_ready = 2'b11;
        repeat (3) step();
        chk("mc_q0_empty", q0.size(), 0);
        chk("mc_q1_empty", q1.size(), 0);
        chk("mc_idle", out_valid, 0);
        sb_on = 1'b0;

        // Isolate out0 with two beats buffered.
        reconfig(2'd2, 2'd0, 2'b01, n);
        out_ready = '0;
        in_valid = 4'b0100;
        in_data[2] = 40'hE0;
        step();
        in_data[2] = 40'hE1;
        step();
        in_valid = '0;
        chk("iso_full", out_valid[0], 1);
        isolate = 2'b01;
        out_ready = 2'b01;
        step();
        chk("iso_drain1_valid", out_valid[0], 1);
        chk("iso_drain1_data", out_data[0], 40'hE1);
        chk("iso_ready_drop", in_ready[2], 0);
        chk("iso_drain1_isolated", isolated, 0);
        step();
        chk("iso_drain2_valid", out_valid[0], 0);
        chk("iso_drain2_isolated", isolated, 0);
        step();
        chk("iso_done", isolated, 2'b01);
        in_valid = 4'b0100;
        #1;
        chk("iso_blocked", in_ready[2], 0);
        in_valid = '0;
        isolate = '0;
        step();
        chk("iso_release", isolated, 0);
        chk("iso_release_ready", in_ready[2], 1);

        // Abort a drain: contents are kept.
        out_ready = '0;
        in_valid = 4'b0100;
        in_data[2] = 40'hE2;
        step();
        in_valid = '0;
        isolate = 2'b01;
        step();
        chk("abort_drain_valid", out_valid[0], 1);
        isolate = '0;
        step();
        chk("abort_kept_valid", out_valid[0], 1);
        chk("abort_kept_data", out_data[0], 40'hE2);
        chk("abort_live", in_ready[2], 1);

        // Reconfigure while out0 is full and stalled.
        in_valid = 4'b0100;
        in_data[2] = 40'hF1;
        step();
        cfg_sel[0] = 2'd1;
        cfg_sel[1] = 2'd3;
        cfg_en = 2'b11;
        cfg_update = 1'b1;
        in_valid = 4'b1111;
        step();
        cfg_update = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("frz_busy_c%0d", c), cfg_busy, 1);
            chk($sformatf("frz_in_ready_c%0d", c), in_ready, 0);
            chk($sformatf("frz_head_c%0d", c), out_data[0], 40'hE2);
            if (c == 1) begin
                cfg_sel = '0;
                cfg_update = 1'b1;
            end
            step();
            cfg_update = 1'b0;
        end
        in_valid = '0;
        out_ready = 2'b01;
        step();
        chk("frz_r1_valid", out_valid[0], 1);
        chk("frz_r1_data", out_data[0], 40'hF1);
        chk("frz_r1_busy", cfg_busy, 1);
        step();
        chk("frz_r2_valid", out_valid[0], 0);
        chk("frz_r2_busy", cfg_busy, 1);
        step();
        chk("frz_apply_busy", cfg_busy, 1);
        step();
        chk("frz_idle", cfg_busy, 0);
        chk("frz_new_route", in_ready, 4'b1010);
        tb_sel[0] = 2'd1; tb_sel[1] = 2'd3; tb_en = 2'b11;

`ifdef ROUTER_TAP_EN
        tap_sel = 1'b1;
        out_ready = 2'b10;
        step();
        in_valid = 4'b1000;
        for (int c = 0; c < 7; c++) begin
            in_data[3] = 40'h70 + 40'(c);
            step();
            chk($sformatf("tap_valid_c%0d", c), tap_valid, 1);
        end
        in_valid = '0;
        repeat (2) step();
        chk("tap_beats_7", tap_beats, 7);
        tap_sel = 1'b0;
        step();
        chk("tap_beats_clear", tap_beats, 0);
`endif

        // Random traffic: single-cast, then multicast, scoreboarded.
        sb_on = 1'b1;
        out_ready = '0;
        for (int c = 0; c < 1500; c++) begin
            in_valid = 4'($urandom);
            out_ready = 2'($urandom);
            for (int i = 0; i < NI; i++) in_data[i] = {8'(i), 32'($urandom)};
            step();
        end
        in_valid = '0;
        out_ready = 2'b11;
        reconfig(2'd3, 2'd3, 2'b11, n);
        for (int c = 0; c < 1500; c++) begin
            in_valid = 4'($urandom);
            out_ready = 2'($urandom);
            for (int i = 0; i < NI; i++) in_data[i] = {8'(i), 32'($urandom)};
            step();
        end
        in_valid = '0;
        out_ready = 2'b11;
        repeat (4) step();
        chk("rand_q0_empty", q0.size(), 0);
        chk("rand_q1_empty", q1.size(), 0);

        // Asynchronous reset in the middle of traffic.
        for (int c = 0; c < 200; c++) begin
            in_valid = 4'($urandom);
            out_ready = 2'($urandom);
            for (int i = 0; i < NI; i++) in_data[i] = {8'(i), 32'($urandom)};
            step();
        end
        sb_on = 1'b0;
        out_ready = '0;
        in_valid = 4'b1111;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_out_data", out_data, 0);
        chk("mid_reset_in_ready", in_ready, 0);
        chk("mid_reset_busy", cfg_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("after_reset_out_valid", out_valid, 0);
        chk("after_reset_in_ready", in_ready, 0);
        q0.delete();
        q1.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
